// File: rtl/imem_loader.sv
// Instruction memory with a registered, fixed-latency read port and a
// byte-serial little-endian program loader that fills it while the core is held off.
module imem_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 11,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_end,
  output logic              busy,
  output logic              ld_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] ld_ptr;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W-1:0] asm_next;
  logic              word_full;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_accept;

  logic [DATA_W-1:0] pipe_data [READ_LAT];
  logic              pipe_vld  [READ_LAT];

  // Lanes above the counter are always zero, so OR-ing in the new byte is enough.
  assign asm_next  = asm_word | (DATA_W'(ld_byte) << {byte_cnt, 3'b000});
  assign word_full = (byte_cnt == CNT_W'(BYTES - 1));

  // Starting a load outranks a read sampled on the same edge.
  assign rd_accept = (state == IDLE) && rd_en && !ld_start;

  always_comb begin
    wr_en   = 1'b0;
    wr_data = asm_word;
    if (!rst && state == LOAD) begin
      if (ld_valid) begin
        wr_en   = word_full || ld_end;
        wr_data = asm_next;
      end else begin
        wr_en   = ld_end && (byte_cnt != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ld_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ld_done  <= 1'b0;
      byte_cnt <= '0;
      ld_ptr   <= '0;
      asm_word <= '0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            ld_ptr   <= ld_base;
            byte_cnt <= '0;
            asm_word <= '0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            if (word_full) begin
              ld_ptr   <= ld_ptr + 1'b1;
              byte_cnt <= '0;
              asm_word <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              asm_word <= asm_next;
            end
          end
          // An end in the same cycle as a byte closes the session after that byte's write.
          if (ld_end) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ld_done  <= 1'b1;
            byte_cnt <= '0;
            asm_word <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld[0]  <= 1'b0;
      pipe_data[0] <= '0;
    end else begin
      pipe_vld[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data[0] <= mem[rd_addr];
      end
    end
  end

  // Data stages only advance with a valid so rd_data holds between reads.
  for (genvar s = 1; s < READ_LAT; s++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_vld[s]  <= 1'b0;
        pipe_data[s] <= '0;
      end else begin
        pipe_vld[s] <= pipe_vld[s-1];
        if (pipe_vld[s-1]) begin
          pipe_data[s] <= pipe_data[s-1];
        end
      end
    end
  end

  assign rd_data  = pipe_data[READ_LAT-1];
  assign rd_valid = pipe_vld[READ_LAT-1];

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed load/read scenarios plus random traffic,
// checked every cycle against a byte-queue/associative-array reference model.
module tb_imem_loader;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 11;
  localparam int READ_LAT = 3;
  localparam int DEPTH    = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ld_start = 1'b0;
  logic [ADDR_W-1:0] ld_base = '0;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_byte = '0;
  logic              ld_end = 1'b0;
  logic              busy;
  logic              ld_done;

  always #5 clk = ~clk;

  imem_loader #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .ld_start(ld_start),
    .ld_base (ld_base),
    .ld_valid(ld_valid),
    .ld_byte (ld_byte),
    .ld_end  (ld_end),
    .busy    (busy),
    .ld_done (ld_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: memory as an associative array, the word being loaded as a byte queue,
  // pending reads as a queue stamped with the edge on which their result appears.
  typedef struct {
    int          due;
    bit          known;
    logic [31:0] d;
  } rd_t;

  logic [31:0] mm [int];
  logic [7:0]  bq [$];
  rd_t         rq [$];
  int          cyc = 0;
  int          m_ptr = 0;
  bit          m_busy = 0, m_done = 0, m_valid = 0, m_known = 1;
  logic [31:0] m_data = '0;

  task automatic commit_word();
    logic [31:0] w;
    w = '0;
    foreach (bq[i]) w = w | (32'(bq[i]) << (8 * i));
    mm[m_ptr] = w;
    m_ptr = (m_ptr + 1) % DEPTH;
    bq.delete();
  endtask

  always @(posedge clk) begin
    rd_t e;
    cyc++;
    m_valid = 0;
    m_done  = 0;
    if (rst) begin
      m_busy  = 0;
      bq.delete();
      rq.delete();
      m_data  = '0;
      m_known = 1;
    end else begin
      if (!m_busy) begin
        if (ld_start) begin
          m_busy = 1;
          m_ptr  = int'(ld_base);
          bq.delete();
        end else if (rd_en) begin
          e.due   = cyc + READ_LAT - 1;
          e.known = mm.exists(int'(rd_addr));
          e.d     = e.known ? mm[int'(rd_addr)] : 32'h0;
          rq.push_back(e);
        end
      end else begin
        if (ld_valid) begin
          bq.push_back(ld_byte);
          if (bq.size() == DATA_W / 8) commit_word();
        end
        if (ld_end) begin
          if (bq.size() > 0) commit_word();
          m_busy = 0;
          m_done = 1;
        end
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e       = rq.pop_front();
        m_valid = 1;
        m_data  = e.d;
        m_known = e.known;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("rd_valid", rd_valid, m_valid);
      check("busy", busy, m_busy);
      check("ld_done", ld_done, m_done);
      if (m_known) check("rd_data", rd_data, m_data);
    end
  end

  // mode 0: separate ld_end cycle, 1: ld_end with last byte, 2: no end
  task automatic load(input logic [ADDR_W-1:0] base, input logic [127:0] val,
                      input int n, input int mode);
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = base;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'(val >> (8 * i));
      ld_end   = (mode == 1) && (i == n - 1);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_end   = 1'b0;
    if (mode == 0) begin
      ld_end = 1'b1;
      @(negedge clk);
      ld_end = 1'b0;
    end
  endtask

  task automatic read_expect(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    int k;
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    k = 0;
    while (!rd_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_lat"}, k, READ_LAT - 1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    int k;
    // Reset held with a read request pending.
    rd_en = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rd_valid && k < 8);
    check("rst_release_lat", k, READ_LAT);
    rd_en = 1'b0;
    repeat (4) @(negedge clk);

    load(11'h010, 128'hDEADBEEF12345678, 8, 0);
    read_expect(11'h010, 32'h12345678, "rd_010");
    read_expect(11'h011, 32'hDEADBEEF, "rd_011");

    load(11'h7FF, 128'h5544332211, 5, 1);
    read_expect(11'h7FF, 32'h44332211, "rd_7ff");
    read_expect(11'h000, 32'h00000055, "rd_000_wrap");

    // Back-to-back reads; the model checks their order and timing.
    load(11'h012, 128'h0BADC0DE, 4, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_en   = 1'b1;
      rd_addr = 11'(16 + i);
    end
    @(negedge clk);
    rd_en = 1'b0;
    repeat (5) @(negedge clk);

    // Read issued just before ld_start, rd_en held through the session.
    rd_en   = 1'b1;
    rd_addr = 11'h010;
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = 11'h010;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'(32'hCAFEF00D >> (8 * i));
      ld_end   = (i == 3);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_end   = 1'b0;
    repeat (4) @(negedge clk);
    rd_en = 1'b0;
    repeat (4) @(negedge clk);
    read_expect(11'h010, 32'hCAFEF00D, "rd_010_new");

    // Reset in the middle of the third word.
    load(11'h100, 128'h33333333_22222222_11111111, 12, 0);
    load(11'h100, 128'hBBBB_AAAAAAAA_99999999, 10, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_expect(11'h100, 32'h99999999, "rd_100");
    read_expect(11'h101, 32'hAAAAAAAA, "rd_101");
    read_expect(11'h102, 32'h33333333, "rd_102_kept");

    // Random traffic over a preloaded window.
    for (int b = 0; b < 64; b += 4) begin
      load(11'(b), {$urandom, $urandom, $urandom, $urandom}, 16, 0);
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 199) == 0);
      rd_en    = 1'($urandom_range(0, 1));
      rd_addr  = 11'($urandom_range(0, 63));
      ld_start = ($urandom_range(0, 19) == 0);
      ld_base  = 11'($urandom_range(0, 63));
      ld_valid = ($urandom_range(0, 9) < 6);
      ld_byte  = 8'($urandom);
      ld_end   = ($urandom_range(0, 14) == 0);
    end
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    ld_end = 1'b1;
    @(negedge clk);
    ld_end = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
